dbg_ram_arbiter: RTL and testbench

Shares the CPU's single-port on-chip debug RAM (1-cycle read latency) between the CPU's Avalon-MM debug slave port and JTAG-originated monitor accesses. It sits in the `clk` domain directly behind the debug-slave sysclk logic, consuming its `jdo` and `take_*_ocimem_*` strobes. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-slave TCK side. Arbitration is CPU-priority with a starvation bound for JTAG.

---
 rtl/dbg_ram_pkg.sv | 15 +
 rtl/dbg_ram_jtag_req.sv | 99 +++++++++
 rtl/dbg_ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_dbg_ram_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_ram_pkg.sv
// dbg_ram_arbiter shared types: FSM states and jdo field positions.
// Optional CPU write protect of the upper half is enabled by DBG_RAM_WP_EN.
package dbg_ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CRD  = 2'd1,
        JRD  = 2'd2
    } state_t;

    localparam int JDO_ADDR_LSB  = 18;
    localparam int JDO_RD_BIT    = 17;
    localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/dbg_ram_jtag_req.sv
// JTAG monitor request capture: pending slot, monitor address,
// write buffer, read-data register and ready/error flags.
module dbg_ram_jtag_req #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       i_jdo,
    input  logic              i_take_a,
    input  logic              i_take_b,
    input  logic              i_take_na,
    input  logic              i_busy,
    input  logic              i_wr_done,
    input  logic              i_rd_done,
    input  logic [31:0]       i_rdata,
    output logic              o_jpend,
    output logic              o_jwr,
    output logic [ADDR_W-1:0] o_mon_addr,
    output logic [31:0]       o_wbuf,
    output logic [31:0]       o_mondreg,
    output logic              o_ready,
    output logic              o_error
);
    import dbg_ram_pkg::*;

    logic              r_jpend;
    logic              r_jwr;
    logic [ADDR_W-1:0] r_mon_addr;
    logic [31:0]       r_wbuf;
    logic [31:0]       r_mondreg;
    logic              r_ready;
    logic              r_error;

    logic              w_any;
    logic              w_reject;
    logic              w_accept;
    logic              w_done;
    logic [ADDR_W-1:0] w_addr;
    logic              w_unused;

    assign w_any    = i_take_a | i_take_b | i_take_na;
    assign w_reject = w_any & (r_jpend | i_busy);
    assign w_accept = w_any & ~w_reject;
    assign w_done   = i_wr_done | i_rd_done;
    assign w_addr   = i_jdo[JDO_ADDR_LSB +: ADDR_W];
    assign w_unused = ^{i_jdo[37:35], i_jdo[2:0]};

    // A completion only happens with the slot full, so it never
    // coincides with an accepted strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jpend    <= 1'b0;
            r_jwr      <= 1'b0;
            r_mon_addr <= '0;
            r_wbuf     <= '0;
            r_mondreg  <= '0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ready <= 1'b0;
                r_error <= 1'b0;
                if (i_take_a) begin
                    r_mon_addr <= w_addr;
                    if (i_jdo[JDO_RD_BIT]) begin
                        r_jpend <= 1'b1;
                        r_jwr   <= 1'b0;
                    end
                end else if (i_take_b) begin
                    r_jpend <= 1'b1;
                    r_jwr   <= 1'b1;
                    r_wbuf  <= i_jdo[JDO_WDATA_LSB +: 32];
                end else begin
                    r_jpend <= 1'b1;
                    r_jwr   <= 1'b0;
                end
            end else if (w_reject) begin
                r_error <= 1'b1;
            end
            if (w_done) begin
                r_jpend    <= 1'b0;
                r_ready    <= 1'b1;
                r_mon_addr <= r_mon_addr + ADDR_W'(1);
            end
            if (i_rd_done) begin
                r_mondreg <= i_rdata;
            end
        end
    end

    assign o_jpend    = r_jpend;
    assign o_jwr      = r_jwr;
    assign o_mon_addr = r_mon_addr;
    assign o_wbuf     = r_wbuf;
    assign o_mondreg  = r_mondreg;
    assign o_ready    = r_ready;
    assign o_error    = r_error;

endmodule

// File: rtl/dbg_ram_arbiter.sv
// Debug RAM arbiter: CPU-priority sharing with a JTAG starvation bound.
// Define DBG_RAM_WP_EN to block CPU writes to the upper address half.
module dbg_ram_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);
    import dbg_ram_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_starve;
    logic [31:0]       r_readdata;

    logic              w_jpend;
    logic              w_jwr;
    logic [ADDR_W-1:0] w_mon_addr;
    logic [31:0]       w_wbuf;
    logic              w_cpu_req;
    logic              w_starved;
    logic              w_wp;
    logic              w_jgrant;
    logic              w_cgrant;
    logic              w_jwr_done;
    logic              w_jrd_done;
    logic              w_wren;
    logic              w_wait;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_byteen;
    logic [31:0]       w_wdata;

    dbg_ram_jtag_req #(.ADDR_W(ADDR_W)) u_jreq (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_jdo      (jdo),
        .i_take_a   (take_action_ocimem_a),
        .i_take_b   (take_action_ocimem_b),
        .i_take_na  (take_no_action_ocimem_a),
        .i_busy     (r_state == JRD),
        .i_wr_done  (w_jwr_done),
        .i_rd_done  (w_jrd_done),
        .i_rdata    (ram_rdata),
        .o_jpend    (w_jpend),
        .o_jwr      (w_jwr),
        .o_mon_addr (w_mon_addr),
        .o_wbuf     (w_wbuf),
        .o_mondreg  (MonDReg),
        .o_ready    (monitor_ready),
        .o_error    (monitor_error)
    );

`ifdef DBG_RAM_WP_EN
    assign w_wp = avs_address[ADDR_W-1];
`else
    assign w_wp = 1'b0;
`endif

    assign w_cpu_req = avs_read | avs_write;
    assign w_starved = (r_starve == 4'(STARVE_MAX));

    always_comb begin
        w_next     = r_state;
        w_addr     = avs_address;
        w_wren     = 1'b0;
        w_byteen   = avs_byteenable;
        w_wdata    = avs_writedata;
        w_wait     = 1'b1;
        w_jgrant   = 1'b0;
        w_cgrant   = 1'b0;
        w_jwr_done = 1'b0;
        w_jrd_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_jpend && (!w_cpu_req || w_starved)) begin
                    w_jgrant = 1'b1;
                    w_addr   = w_mon_addr;
                    if (w_jwr) begin
                        w_wren     = 1'b1;
                        w_byteen   = 4'hF;
                        w_wdata    = w_wbuf;
                        w_jwr_done = 1'b1;
                    end else begin
                        w_next = JRD;
                    end
                end else if (w_cpu_req) begin
                    w_cgrant = 1'b1;
                    // read+write together is handled as a write
                    if (avs_write) begin
                        w_wren = ~w_wp;
                        w_wait = 1'b0;
                    end else begin
                        w_next = CRD;
                    end
                end
            end
            CRD: begin
                w_wait = 1'b0;
                w_next = IDLE;
            end
            JRD: begin
                w_jrd_done = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_starve   <= '0;
            r_readdata <= '0;
        end else begin
            r_state <= w_next;
            if (!w_jpend || w_jgrant) begin
                r_starve <= '0;
            end else if (w_cgrant && !w_starved) begin
                r_starve <= r_starve + 4'd1;
            end
            if (r_state == CRD) begin
                r_readdata <= ram_rdata;
            end
        end
    end

    // reset gates the strobes so nothing reaches the RAM while asserted
    assign ram_wren        = w_wren & reset_n;
    assign avs_waitrequest = w_wait | ~reset_n;
    assign ram_addr        = w_addr;
    assign ram_byteen      = w_byteen;
    assign ram_wdata       = w_wdata;
    assign avs_readdata    = (r_state == CRD) ? ram_rdata : r_readdata;

endmodule

// File: tb/tb_dbg_ram_arbiter.sv
// Randomized bench for dbg_ram_arbiter against a transaction-level
// memory/monitor-pointer model; define DBG_RAM_WP_EN to match the RTL build.
module tb_dbg_ram_arbiter;

    localparam int AW   = 8;
    localparam int SMAX = 4;
`ifdef DBG_RAM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [37:0]   jdo = '0;
    logic          take_a = 1'b0;
    logic          take_b = 1'b0;
    logic          take_na = 1'b0;
    logic [AW-1:0] avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [3:0]    avs_byteenable = 4'hF;
    logic [31:0]   avs_readdata;
    logic          avs_waitrequest;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [3:0]    ram_byteen;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [31:0]   MonDReg;
    logic          monitor_ready;
    logic          monitor_error;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] ram [256];
    bit          ram_valid [256];
    logic [31:0] ref_mem [256];
    logic [7:0]  ref_mon;

    always #5 clk = ~clk;

    dbg_ram_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_na),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_byteen              (ram_byteen),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    function automatic logic [31:0] seed_word(input logic [7:0] a);
        return ({24'd0, a} * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ram_word(input logic [7:0] a);
        return ram_valid[a] ? ram[a] : seed_word(a);
    endfunction

    // single-port RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (ram_wren) begin
            ram[ram_addr]       <= merge(ram_word(ram_addr), ram_wdata, ram_byteen);
            ram_valid[ram_addr] <= 1'b1;
        end
        ram_rdata <= ram_word(ram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
        logic [37:0] j = '0;
        j[25:18] = a;
        j[17]    = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic strobe(input int kind, input logic [37:0] j);
        @(posedge clk); #1;
        jdo     = j;
        take_a  = (kind == 0);
        take_b  = (kind == 1);
        take_na = (kind == 2);
        @(posedge clk); #1;
        take_a  = 1'b0;
        take_b  = 1'b0;
        take_na = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int exp_lat);
        int cyc = 1;
        @(negedge clk);
        while (!monitor_ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_rdy"}, 32'(monitor_ready), 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        int   cyc = 1;
        logic wr_seen;
        bit   blocked = WP_ON && a[7];
        @(posedge clk); #1;
        avs_address    = a;
        avs_write      = 1'b1;
        avs_writedata  = d;
        avs_byteenable = be;
        @(negedge clk);
        while (avs_waitrequest && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        wr_seen = ram_wren;
        chk("cpu_wr_wait", 32'(avs_waitrequest), 32'd0);
        chk("cpu_wr_lat", 32'(cyc), 32'd1);
        chk("cpu_wr_wren", 32'(wr_seen), blocked ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        avs_write = 1'b0;
        if (!blocked) ref_mem[a] = merge(ref_mem[a], d, be);
    endtask

    task automatic cpu_read(input logic [7:0] a);
        int cyc = 1;
        @(posedge clk); #1;
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        while (avs_waitrequest && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("cpu_rd_lat", 32'(cyc), 32'd2);
        chk("cpu_rd_data", avs_readdata, ref_mem[a]);
        @(posedge clk); #1;
        avs_read = 1'b0;
        @(negedge clk);
        chk("cpu_rd_hold", avs_readdata, ref_mem[a]);
    endtask

    task automatic jtag_write_at(input logic [7:0] a, input logic [31:0] d);
        strobe(0, jdo_a(a, 1'b0));
        strobe(1, jdo_b(d));
        wait_ready("jwr", 2);
        ref_mem[a] = d;
        ref_mon    = a + 8'd1;
    endtask

    task automatic jtag_read_at(input logic [7:0] a);
        strobe(0, jdo_a(a, 1'b1));
        wait_ready("jrd", 3);
        chk("jrd_data", MonDReg, ref_mem[a]);
        chk("jrd_err", 32'(monitor_error), 32'd0);
        ref_mon = a + 8'd1;
    endtask

    task automatic jtag_read_next();
        strobe(2, 38'd0);
        wait_ready("jnx", 3);
        chk("jnx_data", MonDReg, ref_mem[ref_mon]);
        ref_mon = ref_mon + 8'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int          ncpu;
        int          cyc;
        logic [31:0] d1;

        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(8'(i));
        ref_mon = 8'd0;

        // reset state, with a CPU write pending to show it is held off
        avs_write = 1'b1;
        #12;
        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_ready", 32'(monitor_ready), 32'd0);
        chk("rst_error", 32'(monitor_error), 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        chk("rst_wait", 32'(avs_waitrequest), 32'd1);
        chk("rst_wren", 32'(ram_wren), 32'd0);
        avs_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // write then read-back, then next address via post-increment
        jtag_write_at(8'h10, 32'hDEADBEEF);
        jtag_read_at(8'h10);
        chk("tp1_mondreg", MonDReg, 32'hDEADBEEF);
        jtag_read_next();

        // wrap at the top of the address space
        jtag_write_at(8'hFF, 32'hCAFEF00D);
        chk("wrap_mon", 32'(ref_mon), 32'd0);
        jtag_read_next();
        cpu_read(8'hFF);

        // write-protect boundary
        cpu_write(8'h80, 32'h1234, 4'hF);
        jtag_read_at(8'h80);
        cpu_write(8'h7F, 32'h5678, 4'hF);
        jtag_read_at(8'h7F);

        // overrun: a rejected ocimem_a must not move the monitor address
        strobe(0, jdo_a(8'h40, 1'b0));
        d1 = 32'hA5A51234;
        @(posedge clk); #1;
        jdo    = jdo_b(d1);
        take_b = 1'b1;
        @(posedge clk); #1;
        take_b = 1'b0;
        jdo    = jdo_a(8'h50, 1'b1);
        take_a = 1'b1;
        @(posedge clk); #1;
        take_a = 1'b0;
        @(negedge clk);
        chk("ovr_error", 32'(monitor_error), 32'd1);
        chk("ovr_ready", 32'(monitor_ready), 32'd1);
        ref_mem[8'h40] = d1;
        ref_mon = 8'h41;
        jtag_read_next();
        chk("ovr_err_clr", 32'(monitor_error), 32'd0);
        jtag_read_at(8'h40);

        // starvation: continuous CPU reads against a queued JTAG read
        strobe(0, jdo_a(8'h20, 1'b0));
        ref_mon = 8'h20;
        @(posedge clk); #1;
        avs_address = 8'h05;
        jdo     = 38'd0;
        take_na = 1'b1;
        @(posedge clk); #1;
        take_na  = 1'b0;
        avs_read = 1'b1;
        ncpu = 0;
        cyc  = 0;
        @(negedge clk);
        while (!monitor_ready && cyc < 60) begin
            if (!avs_waitrequest) begin
                ncpu++;
                chk("stv_rdata", avs_readdata, ref_mem[8'h05]);
            end
            @(negedge clk);
            cyc++;
        end
        chk("stv_ready", 32'(monitor_ready), 32'd1);
        chk("stv_grants", 32'(ncpu), 32'(SMAX));
        chk("stv_mondreg", MonDReg, ref_mem[8'h20]);
        ref_mon = 8'h21;
        ncpu = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) ncpu++;
        end
        chk("stv_resume", 32'(ncpu), 32'd3);
        @(posedge clk); #1;
        avs_read = 1'b0;

        // randomized mix
        for (int i = 0; i < 80; i++) begin
            logic [7:0]  a = 8'($urandom_range(0, 255));
            logic [31:0] d = $urandom;
            case ($urandom_range(0, 4))
                0: cpu_write(a, d, 4'($urandom_range(0, 15)));
                1: cpu_read(a);
                2: jtag_write_at(a, d);
                3: jtag_read_at(a);
                default: jtag_read_next();
            endcase
        end

        // asynchronous reset while in the JTAG read data phase
        strobe(0, jdo_a(8'h30, 1'b1));
        @(posedge clk); #1;
        avs_address   = 8'h31;
        avs_writedata = 32'hFFFF0000;
        avs_write     = 1'b1;
        reset_n       = 1'b0;
        #1;
        chk("mid_mondreg", MonDReg, 32'd0);
        chk("mid_ready", 32'(monitor_ready), 32'd0);
        chk("mid_error", 32'(monitor_error), 32'd0);
        chk("mid_rdata", avs_readdata, 32'd0);
        chk("mid_wait", 32'(avs_waitrequest), 32'd1);
        chk("mid_wren", 32'(ram_wren), 32'd0);
        @(negedge clk);
        chk("mid_wren2", 32'(ram_wren), 32'd0);
        avs_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ref_mon = 8'd0;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", 32'(monitor_ready), 32'd0);
        cpu_read(8'h31);
        jtag_read_next();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
